// File: rtl/lm32_tlb_csr_pkg.sv
// Shared definitions for the DTLB control CSR block: CSR indices,
// TLBCTRL command codes and the flush-busy FSM state encoding.
package lm32_tlb_csr_pkg;

  typedef logic [4:0] csr_idx_t;

  localparam csr_idx_t CSR_TLBVADDR    = 5'h10;
  localparam csr_idx_t CSR_TLBPADDR    = 5'h11;
  localparam csr_idx_t CSR_TLBCTRL     = 5'h12;
  localparam csr_idx_t CSR_TLBBADVADDR = 5'h13;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_UPDATE     = 3'd1,
    CMD_INVALIDATE = 3'd2,
    CMD_FLUSH      = 3'd3,
    CMD_CLEAR      = 3'd4
  } tlb_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tlb_state_e;

endpackage

// File: rtl/lm32_tlb_csr_if.sv
// X-stage rcsr/wcsr bus between the CPU (master) and the TLB CSR block (slave).
interface lm32_tlb_csr_if;
  import lm32_tlb_csr_pkg::*;

  csr_idx_t    csr_x;
  logic        csr_write_enable_x;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;

  modport master (
    output csr_x, csr_write_enable_x, csr_write_data,
    input  csr_read_data
  );

  modport slave (
    input  csr_x, csr_write_enable_x, csr_write_data,
    output csr_read_data
  );
endinterface

// File: rtl/lm32_tlb_csr.sv
// DTLB control CSRs: address registers, one-cycle command pulses, flush-busy FSM.
// Miss address capture (TLBBADVADDR) is built only when CFG_TLB_BADVADDR_EN is defined.
module lm32_tlb_csr
  import lm32_tlb_csr_pkg::*;
#(
  parameter int entries   = 1024,
  parameter int page_size = 4096
) (
  input  logic          clk_i,
  input  logic          rst_i,
  lm32_tlb_csr_if.slave csr,
  input  logic          dtlb_miss,
  input  logic          stall_x,
  input  logic [31:0]   address_x,
  output logic [31:0]   dtlb_vaddr,
  output logic [31:0]   dtlb_paddr,
  output logic          dtlb_update,
  output logic          dtlb_invalidate,
  output logic          dtlb_flush,
  output logic          dtlb_miss_exception
);

  localparam int               offset_width = $clog2(page_size);
  localparam int               CNT_W        = $clog2(entries + 2);
  localparam logic [CNT_W-1:0] FLUSH_LOAD   = CNT_W'(entries + 1);
  localparam logic [31:0]      PAGE_MASK    = ~((32'd1 << offset_width) - 32'd1);

  tlb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      vaddr_q, paddr_q;
  logic             cmd_err_q;
  logic             update_q, invalidate_q, flush_q;
  logic [2:0]       cmd;
  logic             ctrl_wr, is_cmd, busy, accept, clear_status;
  logic             miss_pending;
  logic [31:0]      badvaddr;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    ctrl_wr      = csr.csr_write_enable_x && (csr.csr_x == CSR_TLBCTRL);
    cmd          = csr.csr_write_data[2:0];
    is_cmd       = ctrl_wr && (cmd == CMD_UPDATE || cmd == CMD_INVALIDATE || cmd == CMD_FLUSH);
    busy         = (state_q == ST_FLUSH);
    accept       = is_cmd && !busy;
    clear_status = ctrl_wr && (cmd == CMD_CLEAR);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && cmd == CMD_FLUSH) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Reset mirrors the DTLB power-up flush, so the block comes up busy.
      state_q      <= ST_FLUSH;
      cnt_q        <= FLUSH_LOAD;
      vaddr_q      <= '0;
      paddr_q      <= '0;
      cmd_err_q    <= 1'b0;
      update_q     <= 1'b0;
      invalidate_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      update_q     <= accept && (cmd == CMD_UPDATE);
      invalidate_q <= accept && (cmd == CMD_INVALIDATE);
      flush_q      <= accept && (cmd == CMD_FLUSH);
      if (csr.csr_write_enable_x && csr.csr_x == CSR_TLBVADDR)
        vaddr_q <= csr.csr_write_data & PAGE_MASK;
      if (csr.csr_write_enable_x && csr.csr_x == CSR_TLBPADDR)
        paddr_q <= csr.csr_write_data & PAGE_MASK;
      if (clear_status)
        cmd_err_q <= 1'b0;
      else if (is_cmd && busy)
        cmd_err_q <= 1'b1;
    end
  end

`ifdef CFG_TLB_BADVADDR_EN
  logic [31:0] badvaddr_q;
  logic        miss_pending_q, miss_exc_q, miss_qual;

  assign miss_qual = dtlb_miss && !stall_x && !miss_pending_q;

  // A qualified miss takes priority over a clear-status write in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      badvaddr_q     <= '0;
      miss_pending_q <= 1'b0;
      miss_exc_q     <= 1'b0;
    end else begin
      miss_exc_q <= miss_qual;
      if (miss_qual) begin
        badvaddr_q     <= address_x;
        miss_pending_q <= 1'b1;
      end else if (clear_status) begin
        miss_pending_q <= 1'b0;
      end
    end
  end

  assign miss_pending        = miss_pending_q;
  assign badvaddr            = badvaddr_q;
  assign dtlb_miss_exception = miss_exc_q;
`else
  logic unused_miss_inputs;
  assign unused_miss_inputs  = ^{dtlb_miss, stall_x, address_x};
  assign miss_pending        = 1'b0;
  assign badvaddr            = '0;
  assign dtlb_miss_exception = 1'b0;
`endif

  always_comb begin
    csr.csr_read_data = '0;
    case (csr.csr_x)
      CSR_TLBVADDR:    csr.csr_read_data = vaddr_q;
      CSR_TLBPADDR:    csr.csr_read_data = paddr_q;
      CSR_TLBCTRL:     csr.csr_read_data = {29'b0, cmd_err_q, miss_pending, busy};
      CSR_TLBBADVADDR: csr.csr_read_data = badvaddr;
      default:         csr.csr_read_data = '0;
    endcase
  end

  assign dtlb_vaddr      = vaddr_q;
  assign dtlb_paddr      = paddr_q;
  assign dtlb_update     = update_q;
  assign dtlb_invalidate = invalidate_q;
  assign dtlb_flush      = flush_q;

endmodule

// File: tb/tb_lm32_tlb_csr.sv
// Scoreboard bench for lm32_tlb_csr: stimulus pushes expected reads and pulses,
// a negedge monitor pops and compares. Follows CFG_TLB_BADVADDR_EN like the RTL.
module tb_lm32_tlb_csr;
  import lm32_tlb_csr_pkg::*;

  localparam int          ENTRIES = 1024;
  localparam int          PAGE    = 4096;
  localparam logic [31:0] MASK    = ~(32'(PAGE) - 32'd1);

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        dtlb_miss = 1'b0;
  logic        stall_x = 1'b0;
  logic [31:0] address_x = '0;
  logic [31:0] dtlb_vaddr, dtlb_paddr;
  logic        dtlb_update, dtlb_invalidate, dtlb_flush, dtlb_miss_exception;

  lm32_tlb_csr_if bus ();

  lm32_tlb_csr #(.entries(ENTRIES), .page_size(PAGE)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .csr                 (bus.slave),
    .dtlb_miss           (dtlb_miss),
    .stall_x             (stall_x),
    .address_x           (address_x),
    .dtlb_vaddr          (dtlb_vaddr),
    .dtlb_paddr          (dtlb_paddr),
    .dtlb_update         (dtlb_update),
    .dtlb_invalidate     (dtlb_invalidate),
    .dtlb_flush          (dtlb_flush),
    .dtlb_miss_exception (dtlb_miss_exception)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic [31:0] va;
    logic [31:0] pa;
  } rd_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] p;   // {miss_exception, flush, invalidate, update}
  } pulse_exp_t;

  rd_exp_t    rd_q[$];
  pulse_exp_t pl_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: register contents plus remaining busy cycles.
  logic [31:0] m_vaddr, m_paddr, m_badv;
  logic        m_err, m_pend;
  int          m_busy_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    case (idx)
      CSR_TLBVADDR:    return m_vaddr;
      CSR_TLBPADDR:    return m_paddr;
      CSR_TLBCTRL:     return {29'b0, m_err, m_pend, m_busy_left > 0};
`ifdef CFG_TLB_BADVADDR_EN
      CSR_TLBBADVADDR: return m_badv;
`endif
      default:         return 32'h0;
    endcase
  endfunction

  task automatic step(input logic we, input logic [4:0] idx, input logic [31:0] wd,
                      input logic miss, input logic stall, input logic [31:0] addr);
    logic [3:0] p;
    logic [2:0] code;
    logic       is_ctrl, busy, pend0;
    bus.csr_write_enable_x = we;
    bus.csr_x              = idx;
    bus.csr_write_data     = wd;
    dtlb_miss              = miss;
    stall_x                = stall;
    address_x              = addr;
    rd_q.push_back('{cyc, model_read(idx), m_vaddr, m_paddr});

    p       = '0;
    code    = wd[2:0];
    is_ctrl = we && (idx == CSR_TLBCTRL);
    busy    = m_busy_left > 0;
    pend0   = m_pend;
    m_busy_left = busy ? m_busy_left - 1 : 0;
    if (we && idx == CSR_TLBVADDR) m_vaddr = wd & MASK;
    if (we && idx == CSR_TLBPADDR) m_paddr = wd & MASK;
    if (is_ctrl && (code == CMD_UPDATE || code == CMD_INVALIDATE || code == CMD_FLUSH)) begin
      if (busy) m_err = 1'b1;
      else begin
        case (code)
          CMD_UPDATE:     p[0] = 1'b1;
          CMD_INVALIDATE: p[1] = 1'b1;
          default: begin
            p[2] = 1'b1;
            m_busy_left = ENTRIES + 1;
          end
        endcase
      end
    end
    if (is_ctrl && code == CMD_CLEAR) begin
      m_err  = 1'b0;
      m_pend = 1'b0;
    end
`ifdef CFG_TLB_BADVADDR_EN
    if (miss && !stall && !pend0) begin
      m_badv = addr;
      m_pend = 1'b1;
      p[3]   = 1'b1;
    end
`endif
    if (p != 4'b0) pl_q.push_back('{cyc + 1, p});
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] idx);
    for (int i = 0; i < n; i++) step(1'b0, idx, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] wd);
    step(1'b1, idx, wd, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst_i                  = 1'b1;
    bus.csr_write_enable_x = 1'b0;
    bus.csr_x              = CSR_TLBCTRL;
    bus.csr_write_data     = '0;
    dtlb_miss              = 1'b0;
    stall_x                = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    m_vaddr     = '0;
    m_paddr     = '0;
    m_badv      = '0;
    m_err       = 1'b0;
    m_pend      = 1'b0;
    m_busy_left = ENTRIES + 1;
  endtask

  // Monitor: compares whatever the DUT presents this cycle against the scoreboard.
  always @(negedge clk_i) begin : monitor
    logic [3:0] obs, exp_p;
    rd_exp_t    r;
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      r = rd_q.pop_front();
      check("csr_read_data", bus.csr_read_data, r.rd);
      check("dtlb_vaddr", dtlb_vaddr, r.va);
      check("dtlb_paddr", dtlb_paddr, r.pa);
    end
    obs   = {dtlb_miss_exception, dtlb_flush, dtlb_invalidate, dtlb_update};
    exp_p = '0;
    if (pl_q.size() > 0 && pl_q[0].cyc == cyc) exp_p = pl_q.pop_front().p;
    if (obs != 4'b0 || exp_p != 4'b0) check("pulses", 32'(obs), 32'(exp_p));
  end

  initial begin
    bus.csr_write_enable_x = 1'b0;
    bus.csr_x              = CSR_TLBCTRL;
    bus.csr_write_data     = '0;

    // Power-up flush: busy for entries+1 cycles after release.
    do_reset(3);
    idle(ENTRIES + 4, CSR_TLBCTRL);

    // Address registers with page offset cleared, then an update command.
    wr(CSR_TLBVADDR, 32'h12345ABC);
    wr(CSR_TLBPADDR, 32'h00080FFF);
    wr(CSR_TLBCTRL, 32'h1);
    idle(2, CSR_TLBVADDR);
    wr(CSR_TLBCTRL, 32'h2);
    idle(2, CSR_TLBPADDR);

    // Flush, then a dropped update five cycles later.
    wr(CSR_TLBCTRL, 32'h3);
    idle(4, CSR_TLBCTRL);
    wr(CSR_TLBCTRL, 32'h1);
    idle(ENTRIES + 3, CSR_TLBCTRL);

    // Miss capture: only the first miss is recorded.
    step(1'b0, CSR_TLBBADVADDR, 32'h0, 1'b1, 1'b0, 32'hC0001234);
    step(1'b0, CSR_TLBBADVADDR, 32'h0, 1'b1, 1'b0, 32'hC0009000);
    idle(3, CSR_TLBBADVADDR);
    idle(1, CSR_TLBCTRL);

    // Clear alone, then miss and clear together.
    wr(CSR_TLBCTRL, 32'h4);
    idle(1, CSR_TLBCTRL);
    step(1'b1, CSR_TLBCTRL, 32'h4, 1'b1, 1'b0, 32'hC0009000);
    idle(1, CSR_TLBCTRL);
    idle(1, CSR_TLBBADVADDR);
    wr(CSR_TLBCTRL, 32'h4);
    idle(2, CSR_TLBCTRL);

    // Reset in the middle of a flush restarts the full count.
    wr(CSR_TLBCTRL, 32'h3);
    idle(100, CSR_TLBCTRL);
    do_reset(2);
    idle(ENTRIES + 4, CSR_TLBCTRL);

    for (int i = 0; i < 2000; i++) begin
      logic        we;
      logic [4:0]  idx;
      logic [31:0] wd;
      we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       idx = CSR_TLBVADDR;
        1:       idx = CSR_TLBPADDR;
        2, 3:    idx = CSR_TLBCTRL;
        4:       idx = CSR_TLBBADVADDR;
        default: idx = 5'($urandom);
      endcase
      wd = $urandom;
      if (wd[2:0] == 3'd3 && $urandom_range(0, 3) != 0) wd[2:0] = 3'd1;
      step(we, idx, wd, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom);
    end

    idle(5, CSR_TLBCTRL);
    @(negedge clk_i);
    #1;
    check("pulse_queue_drained", 32'(pl_q.size()), 32'd0);
    check("read_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
